// File: rtl/seg_sched_pkg.sv
// Shared state encoding, BCD constants and word type for the seven-segment display scheduler.
package seg_sched_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} sched_state_t;

  localparam int BCD_DIGITS = 6;
  localparam int MAX_DEC    = 999999;

  typedef logic [4*BCD_DIGITS-1:0] bcd_word_t;
endpackage

// File: rtl/seg_bcd_iter.sv
// Iterative shift-add-3 binary to BCD converter: one bit per cycle, IN_W cycles per value.
module seg_bcd_iter
  import seg_sched_pkg::*;
#(
  parameter int IN_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            done,
  output bcd_word_t       bcd
);
  localparam int SR_W = 4*BCD_DIGITS + IN_W;
  localparam int CW   = $clog2(IN_W+1);

  logic [SR_W-1:0] sr, sr_step;
  logic [CW-1:0]   cnt;

  always_comb begin
    sr_step = sr;
    for (int d = 0; d < BCD_DIGITS; d++)
      if (sr_step[IN_W+4*d +: 4] >= 4'd5)
        sr_step[IN_W+4*d +: 4] = sr_step[IN_W+4*d +: 4] + 4'd3;
    sr_step = sr_step << 1;
  end

  // bcd is the result of the step in progress; it is final only while done is high
  assign done = (cnt == CW'(1));
  assign bcd  = sr_step[SR_W-1 -: 4*BCD_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= {{(4*BCD_DIGITS){1'b0}}, bin};
      cnt <= CW'(IN_W);
    end else if (cnt != '0) begin
      sr  <= sr_step;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing one six-digit BCD display among NUM_REQ requesters.
// Optional SEG_SCHED_LZ_BLANK_EN adds the digit_blank leading-zero mask output.
module seg_disp_sched
  import seg_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int IN_W        = 20,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*IN_W-1:0] value_in,
  output logic [NUM_REQ-1:0]      ack,
  output logic [23:0]             disp_value,
  output logic                    disp_on,
`ifdef SEG_SCHED_LZ_BLANK_EN
  output logic [5:0]              digit_blank,
`endif
  output logic                    busy
);
  localparam int PW   = $clog2(NUM_REQ);
  localparam int HW   = $clog2(HOLD_CYCLES);
  localparam int SELW = IN_W + 24;
  localparam logic [SELW-1:0] MAX_W = SELW'(MAX_DEC);

  sched_state_t     state, state_nx;
  logic [PW-1:0]    rr_ptr, grant_idx, jj;
  logic [HW-1:0]    hold_cnt;
  logic             grant_any, start, conv_done, load_disp;
  logic [NUM_REQ-1:0] ack_c;
  logic [IN_W-1:0]  sel, clamped;
  bcd_word_t        conv_bcd;
  int               j;

  // Lowest offset from rr_ptr wins, so scan offsets from high to low
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    j         = 0;
    jj        = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = PW'(j);
      if (req[jj]) begin
        grant_any = 1'b1;
        grant_idx = jj;
      end
    end
  end

  always_comb begin
    sel     = value_in[int'(grant_idx)*IN_W +: IN_W];
    clamped = ({24'd0, sel} > MAX_W) ? MAX_W[IN_W-1:0] : sel;
  end

  seg_bcd_iter #(.IN_W(IN_W)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (clamped),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start     = 1'b0;
    ack_c     = '0;
    load_disp = 1'b0;
    case (state)
      IDLE: if (grant_any) begin
        ack_c[grant_idx] = 1'b1;
        start            = 1'b1;
        state_nx         = CONVERT;
      end
      CONVERT: if (conv_done) begin
        load_disp = 1'b1;
        state_nx  = HOLD;
      end
      HOLD: if (hold_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ack is a Mealy output off req; keep it quiet while reset is held
  assign ack  = rst_n ? ack_c : '0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      hold_cnt   <= '0;
      disp_value <= '0;
      disp_on    <= 1'b0;
    end else begin
      if (start)
        rr_ptr <= (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + PW'(1);
      if (load_disp) begin
        disp_value <= conv_bcd;
        disp_on    <= 1'b1;
        hold_cnt   <= HW'(HOLD_CYCLES-1);
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

`ifdef SEG_SCHED_LZ_BLANK_EN
  logic [5:0] blank_nx;
  logic       lead;

  // Digit 0 is never blanked so a zero value still shows "0"
  always_comb begin
    blank_nx = '0;
    lead     = 1'b1;
    for (int k = BCD_DIGITS-1; k >= 1; k--) begin
      lead        = lead & (conv_bcd[4*k +: 4] == 4'd0);
      blank_nx[k] = lead;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         digit_blank <= '0;
    else if (load_disp) digit_blank <= blank_nx;
  end
`endif
endmodule

// File: tb/tb_seg_disp_sched.sv
// Self-checking bench for seg_disp_sched: directed scenarios plus randomized traffic against a timeline model.
module tb_seg_disp_sched;
  localparam int NUM_REQ = 3;
  localparam int IN_W    = 20;
  localparam int HOLD    = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic [NUM_REQ*IN_W-1:0] value_in = '0;
  logic [NUM_REQ-1:0]      ack;
  logic [23:0]             disp_value;
  logic                    disp_on, busy;
`ifdef SEG_SCHED_LZ_BLANK_EN
  logic [5:0]              digit_blank;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seg_disp_sched #(.NUM_REQ(NUM_REQ), .IN_W(IN_W), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .value_in   (value_in),
    .ack        (ack),
    .disp_value (disp_value),
    .disp_on    (disp_on),
`ifdef SEG_SCHED_LZ_BLANK_EN
    .digit_blank(digit_blank),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int clampv(input int v);
    return (v > 999999) ? 999999 : v;
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    int x;
    logic [23:0] r;
    x = clampv(v);
    r = '0;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_blank(input int v);
    int x, p;
    logic [5:0] b;
    x = clampv(v);
    b = '0;
    p = 10;
    for (int k = 1; k < 6; k++) begin
      b[k] = (x < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic set_val(input int i, input int v);
    value_in[i*IN_W +: IN_W] = IN_W'(v);
  endtask

  function automatic int get_val(input int i);
    return int'(value_in[i*IN_W +: IN_W]);
  endfunction

  task automatic apply_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns the cycle in which ack is seen, or -1 when the bound expires
  task automatic wait_ack(output int t);
    t = -1;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (ack != '0) begin
        t = cyc;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    #3;
    checks++;
    if ({ack, busy, disp_on, disp_value} !== '0) begin
      failures++;
      $display("FAIL reset_assert ack=%b busy=%b on=%b disp=%h exp all zero", ack, busy, disp_on, disp_value);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      checks++;
      if ({ack, busy, disp_on, disp_value} !== '0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d ack=%b busy=%b on=%b disp=%h exp all zero", n, ack, busy, disp_on, disp_value);
      end
    end
  endtask

  task automatic test_single();
    int t;
    apply_reset();
    set_val(0, 146);
    req[0] = 1'b1;
    wait_ack(t);
    checks++;
    if (t < 0 || ack !== 3'b001) begin
      failures++;
      $display("FAIL single_ack ack=%b exp=001 t=%0d", ack, t);
    end
    if (t < 0) return;
    @(posedge clk); #1 req[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== '0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_pulse ack=%b busy=%b exp ack=000 busy=1", ack, busy);
    end
    wait_until(t + 20);
    checks++;
    if (disp_on !== 1'b0 || disp_value !== 24'h0) begin
      failures++;
      $display("FAIL single_early on=%b disp=%h exp on=0 disp=000000", disp_on, disp_value);
    end
    wait_until(t + 21);
    checks++;
    if (disp_on !== 1'b1 || disp_value !== 24'h000146) begin
      failures++;
      $display("FAIL single_disp on=%b disp=%h exp on=1 disp=000146", disp_on, disp_value);
    end
    wait_until(t + 28);
    checks++;
    if (busy !== 1'b1 || disp_value !== 24'h000146) begin
      failures++;
      $display("FAIL single_hold busy=%b disp=%h exp busy=1 disp=000146", busy, disp_value);
    end
    wait_until(t + 29);
    checks++;
    if (busy !== 1'b0 || disp_on !== 1'b1 || disp_value !== 24'h000146) begin
      failures++;
      $display("FAIL single_idle busy=%b on=%b disp=%h exp busy=0 on=1 disp=000146", busy, disp_on, disp_value);
    end
  endtask

  task automatic test_pair();
    int t, prev;
    logic [NUM_REQ-1:0] exp_ack;
    apply_reset();
    set_val(0, 123456);
    set_val(1, 654321);
    for (int rep = 0; rep < 2; rep++) begin
      req  = 3'b011;
      prev = -1;
      for (int e = 0; e < 2; e++) begin
        exp_ack = NUM_REQ'(1) << e;
        wait_ack(t);
        checks++;
        if (t < 0 || ack !== exp_ack) begin
          failures++;
          $display("FAIL pair_ack rep=%0d ack=%b exp=%b t=%0d", rep, ack, exp_ack, t);
        end
        if (t < 0) return;
        if (prev >= 0) begin
          checks++;
          if (t - prev != IN_W + 1 + HOLD) begin
            failures++;
            $display("FAIL pair_gap rep=%0d gap=%0d exp=%0d", rep, t - prev, IN_W + 1 + HOLD);
          end
        end
        prev = t;
        @(posedge clk); #1 req[e] = 1'b0;
        wait_until(t + 21);
        checks++;
        if (disp_value !== to_bcd(e ? 654321 : 123456)) begin
          failures++;
          $display("FAIL pair_disp rep=%0d e=%0d disp=%h exp=%h", rep, e, disp_value, to_bcd(e ? 654321 : 123456));
        end
      end
    end
  endtask

  task automatic test_clamp();
    int t;
    int vals[3] = '{1048575, 1000000, 999999};
    int who[3]  = '{1, 2, 0};
    logic [NUM_REQ-1:0] exp_ack;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      set_val(who[n], vals[n]);
      req[who[n]] = 1'b1;
      exp_ack = NUM_REQ'(1) << who[n];
      wait_ack(t);
      checks++;
      if (t < 0 || ack !== exp_ack) begin
        failures++;
        $display("FAIL clamp_ack n=%0d ack=%b exp=%b t=%0d", n, ack, exp_ack, t);
      end
      if (t < 0) return;
      @(posedge clk); #1 req[who[n]] = 1'b0;
      wait_until(t + 21);
      checks++;
      if (disp_value !== 24'h999999) begin
        failures++;
        $display("FAIL clamp_disp n=%0d disp=%h exp=999999", n, disp_value);
      end
    end
  endtask

  task automatic test_mid_reset();
    int t;
    apply_reset();
    set_val(0, 146);
    req[0] = 1'b1;
    wait_ack(t);
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL midrst_ack0 timeout");
      return;
    end
    @(posedge clk); #1 req[0] = 1'b0;
    set_val(1, 777);
    req[1] = 1'b1;
    wait_ack(t);
    if (t < 0) begin
      checks++; failures++;
      $display("FAIL midrst_ack1 timeout");
      return;
    end
    @(posedge clk); #1 req[1] = 1'b0;
    wait_until(t + 10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ack, busy, disp_on, disp_value} !== '0) begin
      failures++;
      $display("FAIL midrst_async ack=%b busy=%b on=%b disp=%h exp all zero", ack, busy, disp_on, disp_value);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, disp_on, disp_value} !== '0) begin
      failures++;
      $display("FAIL midrst_after busy=%b on=%b disp=%h exp all zero", busy, disp_on, disp_value);
    end
    set_val(0, 42);
    set_val(2, 9);
    req = 3'b101;
    wait_ack(t);
    checks++;
    if (t < 0 || ack !== 3'b001) begin
      failures++;
      $display("FAIL midrst_rr ack=%b exp=001 t=%0d", ack, t);
    end
    if (t < 0) return;
    @(posedge clk); #1 req[0] = 1'b0;
    wait_until(t + 21);
    checks++;
    if (disp_value !== 24'h000042 || disp_on !== 1'b1) begin
      failures++;
      $display("FAIL midrst_disp on=%b disp=%h exp on=1 disp=000042", disp_on, disp_value);
    end
    req = '0;
  endtask

`ifdef SEG_SCHED_LZ_BLANK_EN
  task automatic test_blank();
    int t;
    int vals[3] = '{5, 0, 100000};
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      set_val(0, vals[n]);
      req[0] = 1'b1;
      wait_ack(t);
      if (t < 0) begin
        checks++; failures++;
        $display("FAIL blank_ack n=%0d timeout", n);
        return;
      end
      @(posedge clk); #1 req[0] = 1'b0;
      wait_until(t + 21);
      checks++;
      if (digit_blank !== exp_blank(vals[n]) || disp_value !== to_bcd(vals[n])) begin
        failures++;
        $display("FAIL blank n=%0d blank=%b disp=%h exp blank=%b disp=%h",
                 n, digit_blank, disp_value, exp_blank(vals[n]), to_bcd(vals[n]));
      end
    end
  endtask
`endif

  // Timeline model: a grant at cycle c shows its value from c+IN_W+1,
  // keeps busy through c+IN_W+HOLD and allows the next grant at c+IN_W+HOLD+1
  task automatic test_random(input int ncyc);
    int rr, free_at, show_at, busy_to, g, c, idx, v;
    logic [23:0] shown, pend;
    logic [5:0]  shown_b, pend_b;
    logic        on;
    logic [NUM_REQ-1:0] exp_ack;
    apply_reset();
    rr = 0; free_at = 0; show_at = -1; busy_to = -1;
    shown = '0; pend = '0; shown_b = '0; pend_b = '0; on = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      #1;
      c = cyc;
      if (show_at >= 0 && c >= show_at) begin
        shown = pend; shown_b = pend_b; on = 1'b1; show_at = -1;
      end
      exp_ack = '0;
      g = -1;
      if (c >= free_at)
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (rr + k) % NUM_REQ;
          if (g < 0 && req[idx]) g = idx;
        end
      if (g >= 0) exp_ack[g] = 1'b1;
      checks++;
      if (ack !== exp_ack) begin
        failures++;
        $display("FAIL rand_ack cyc=%0d ack=%b exp=%b", c, ack, exp_ack);
      end
      checks++;
      if (busy !== (c <= busy_to)) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d busy=%b exp=%b", c, busy, (c <= busy_to));
      end
      checks++;
      if (disp_value !== shown || disp_on !== on) begin
        failures++;
        $display("FAIL rand_disp cyc=%0d disp=%h on=%b exp disp=%h on=%b", c, disp_value, disp_on, shown, on);
      end
`ifdef SEG_SCHED_LZ_BLANK_EN
      checks++;
      if (digit_blank !== shown_b) begin
        failures++;
        $display("FAIL rand_blank cyc=%0d blank=%b exp=%b", c, digit_blank, shown_b);
      end
`endif
      if (g >= 0) begin
        rr      = (g + 1) % NUM_REQ;
        pend    = to_bcd(get_val(g));
        pend_b  = exp_blank(get_val(g));
        show_at = c + IN_W + 1;
        busy_to = c + IN_W + HOLD;
        free_at = busy_to + 1;
      end
      @(posedge clk); #1;
      if (g >= 0) req[g] = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i]) begin
          case ($urandom_range(0, 7))
            0:       v = 0;
            1:       v = 999999;
            2:       v = 1000000;
            3:       v = (1 << IN_W) - 1;
            default: v = int'($urandom_range(0, (1 << IN_W) - 1));
          endcase
          set_val(i, v);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
      end
      @(negedge clk);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_clamp();
    test_mid_reset();
`ifdef SEG_SCHED_LZ_BLANK_EN
    test_blank();
`endif
    test_random(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation time limit reached checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
